spi_slave_reg_ctrl: RTL and testbench
=====================================

# spi_slave_reg_ctrl

Serial command front end that reads and writes the SPI slave configuration register file (QPI enable, dummy cycles, wrap length). It deserialises command and data bits from the SPI pins on `sclk`. On a write, it drives the register file's write port. On a read, it fetches from the register file's read port and serialises the value back out on the data lines. It sits between the pad-level SPI signals and the register file, and runs entirely in the `sclk` domain.

## Interface
- `REG_SIZE`, 8: register width in bits; must be a multiple of 4 when quad support is compiled in.
- `sclk  in  1`: SPI clock; data sampled on posedge, `sdo`/`sdo_oe` updated on negedge.
- `rstn  in  1`: reset, asynchronous, active-low.
- `cs_n  in  1`: chip select, active-low; high asynchronously returns the FSM to CMD and clears counters.
- `sdi  in  4`: serial data in; single mode uses `sdi[0]` only.
- `sdo  out  4`: serial data out; single mode uses `sdo[0]` only.
- `sdo_oe  out  1`: output enable for `sdo`.
- `en_qpi  in  1`: 1 = 4 bits per `sclk`, 0 = 1 bit per `sclk`.
- `dummy_cycles  in  8`: turnaround cycles between the read command and read data.
- `wr_addr  out  2`: register write address.
- `wr_data  out  REG_SIZE`: register write data.
- `wr_data_valid  out  1`: write strobe, sampled by the register file on posedge `sclk`.
- `rd_addr  out  2`: register read address.
- `rd_data  in  REG_SIZE`: register read data, combinational from `rd_addr`.

## Operation
- The command is 8 bits, MSB first: 8 `sclk` in single mode, or 2 `sclk` in quad mode (high nibble first).
- `cmd[7:2]` = 6'h1C (0x70–0x73): write register `cmd[1:0]`.
- `cmd[7:2]` = 6'h1D (0x74–0x77): read register `cmd[1:0]`.
- Any other opcode: go to DONE; no write, `sdo_oe` stays 0.
- FSM states: CMD -> WDATA -> DONE (write), or CMD -> DUMMY -> RDATA -> DONE (read). DONE ignores all bits until `cs_n` goes high.
- WDATA: shift in `REG_SIZE` bits MSB first.
  - During the last bit cycle, `wr_data_valid` = 1 combinationally, and `wr_data` = {shift[REG_SIZE-2:0], `sdi[0]`} (single) or {shift[REG_SIZE-5:0], `sdi[3:0]`} (quad).
  - The register file captures the write on that same posedge.
  - `wr_data_valid` is 0 in every other state.
- `wr_addr` and `rd_addr` are registered from `cmd[1:0]` on the last command posedge and hold until the next command.
- DUMMY: count `max(dummy_cycles,1)` posedges. On the final one, `tx_shift <= rd_data` and the FSM moves to RDATA.
- RDATA: on each negedge, `sdo <= tx_shift` MSB (single: `sdo[0]`, others 0) or top nibble (quad), and `sdo_oe <= 1`. Each posedge shifts `tx_shift` by 1 or 4.
- After `REG_SIZE` bits have been shifted, the FSM goes to DONE; `sdo_oe` clears at the next negedge.
- `en_qpi` is sampled at the start of every state. Changing it mid-command is not supported.
- When `cs_n` goes high mid-transfer, the transfer aborts: no write strobe, `sdo_oe` = 0 immediately, and the next frame starts in CMD.

## Timing
- Reset values: `sdo` = 0, `sdo_oe` = 0, `wr_addr` = 0, `wr_data` = 0, `wr_data_valid` = 0, `rd_addr` = 0; FSM in CMD with counters 0.
- Write latency: zero; the strobe coincides with the last data bit.
- Read latency from the last command bit: `max(dummy_cycles,1)` `sclk`, then data begins on the following negedge.
- Bit counter width: `$clog2(REG_SIZE)+1`; the counter wraps only via a state transition.

## Configuration
- `SPI_REG_CTRL_QPI_EN` defined: quad mode is available and `en_qpi` selects the lane count.
- `SPI_REG_CTRL_QPI_EN` undefined: `en_qpi` is ignored, single lane only, and `sdo[3:1]` is tied to 0.

## Test plan
- Single mode, cmd 0x71 then 0xA5: `wr_data_valid` pulses once on the 16th posedge, with `wr_addr` = 1 and `wr_data` = 0xA5.
- Single mode, cmd 0x76, `dummy_cycles` = 4, `rd_data` = 0x3C: `sdo[0]` shows 0,0,1,1,1,1,0,0 starting on the 5th negedge after the command; `sdo_oe` falls after 8 bits.
- Quad mode (macro defined), cmd 0x73 in 2 clocks then 0x5A in 2 clocks: write to address 3 with data 0x5A on the 4th posedge.
- Cmd 0xFF followed by 16 clocks: no `wr_data_valid`, and `sdo_oe` stays 0 throughout.
- `cs_n` raised after 4 of 8 write data bits, then a fresh 0x70/0x11 frame: no strobe for the aborted frame, then exactly one write of 0x11 to address 0.
- `rstn` pulsed low during RDATA: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: serial command front end for the SPI slave config
// register file. Decodes an 8-bit command, then either shifts in a write
// word (strobed combinationally on its last bit) or waits out the dummy
// cycles and shifts the read word back out on the negative edge.
// Optional build macro: SPI_REG_CTRL_QPI_EN enables 4-lane transfers
// selected by en_qpi; without it the block is single lane only.
module spi_slave_reg_ctrl #(
  parameter int REG_SIZE = 8
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                cs_n,
  input  logic [3:0]          sdi,
  output logic [3:0]          sdo,
  output logic                sdo_oe,
  input  logic                en_qpi,
  input  logic [7:0]          dummy_cycles,
  output logic [1:0]          wr_addr,
  output logic [REG_SIZE-1:0] wr_data,
  output logic                wr_data_valid,
  output logic [1:0]          rd_addr,
  input  logic [REG_SIZE-1:0] rd_data
);

  localparam int CW = $clog2(REG_SIZE) + 1;

  typedef enum logic [2:0] {S_CMD, S_WDATA, S_DUMMY, S_RDATA, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [7:0]          dcnt;
  logic [7:0]          dummy_tgt;
  logic [REG_SIZE-1:0] rx_shift, rx_next, tx_shift;
  logic [7:0]          cmd_word;
  logic                arst_n, qpi;
  logic                cmd_last, bit_last, dm_last;

  // Chip select high acts as an asynchronous frame reset alongside rstn.
  assign arst_n = rstn & ~cs_n;

`ifdef SPI_REG_CTRL_QPI_EN
  assign qpi     = en_qpi;
  assign rx_next = qpi ? {rx_shift[REG_SIZE-5:0], sdi}
                       : {rx_shift[REG_SIZE-2:0], sdi[0]};
`else
  logic [3:0] unused_qpi_in;
  assign unused_qpi_in = {en_qpi, sdi[3:1]};
  assign qpi     = 1'b0;
  assign rx_next = {rx_shift[REG_SIZE-2:0], sdi[0]};
`endif

  // The low byte of the incoming word is the full command on its last clock.
  assign cmd_word  = rx_next[7:0];
  assign cmd_last  = (cnt == (qpi ? CW'(1) : CW'(7)));
  assign bit_last  = (cnt == (qpi ? CW'(REG_SIZE/4 - 1) : CW'(REG_SIZE - 1)));
  // Zero dummy cycles still costs one turnaround clock.
  assign dummy_tgt = (dummy_cycles == 8'd0) ? 8'd0 : dummy_cycles - 8'd1;
  assign dm_last   = (dcnt == dummy_tgt);

  // State register, cleared by reset or chip select deassertion.
  always_ff @(posedge sclk or negedge arst_n) begin
    if (!arst_n) state <= S_CMD;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_CMD: begin
        if (cmd_last) begin
          if (cmd_word[7:2] == 6'h1C)      state_nxt = S_WDATA;
          else if (cmd_word[7:2] == 6'h1D) state_nxt = S_DUMMY;
          else                             state_nxt = S_DONE;
        end
      end
      S_WDATA: if (bit_last) state_nxt = S_DONE;
      S_DUMMY: if (dm_last)  state_nxt = S_RDATA;
      S_RDATA: if (bit_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_CMD;
    endcase
  end

  // Write port: strobe and word are live only during the last data bit.
  always_comb begin
    wr_data_valid = (state == S_WDATA) && bit_last;
    wr_data       = wr_data_valid ? rx_next : '0;
  end

  // Bit and dummy counters; bit counter restarts on every state change.
  always_ff @(posedge sclk or negedge arst_n) begin
    if (!arst_n) begin
      cnt  <= '0;
      dcnt <= '0;
    end else begin
      if (state != state_nxt)
        cnt <= '0;
      else if (state == S_CMD || state == S_WDATA || state == S_RDATA)
        cnt <= cnt + CW'(1);
      dcnt <= (state == S_DUMMY && !dm_last) ? dcnt + 8'd1 : 8'd0;
    end
  end

  // Receive and transmit shift registers.
  always_ff @(posedge sclk or negedge arst_n) begin
    if (!arst_n) begin
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      if (state == S_CMD || state == S_WDATA)
        rx_shift <= rx_next;
      if (state == S_DUMMY && dm_last)
        tx_shift <= rd_data;
      else if (state == S_RDATA)
        tx_shift <= qpi ? {tx_shift[REG_SIZE-5:0], 4'b0000}
                        : {tx_shift[REG_SIZE-2:0], 1'b0};
    end
  end

  // Register addresses latch on the last command bit and survive cs_n.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      wr_addr <= 2'd0;
      rd_addr <= 2'd0;
    end else if (state == S_CMD && cmd_last && !cs_n) begin
      wr_addr <= cmd_word[1:0];
      rd_addr <= cmd_word[1:0];
    end
  end

  // Read data launches on the falling edge so the master samples it on rise.
  always_ff @(negedge sclk or negedge arst_n) begin
    if (!arst_n) begin
      sdo    <= 4'd0;
      sdo_oe <= 1'b0;
    end else if (state == S_RDATA) begin
      sdo_oe <= 1'b1;
      sdo    <= qpi ? tx_shift[REG_SIZE-1 -: 4] : {3'b000, tx_shift[REG_SIZE-1]};
    end else begin
      sdo_oe <= 1'b0;
      sdo    <= 4'd0;
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Self-checking bench for spi_slave_reg_ctrl: directed frames with literal
// expectations, then randomized frames checked every cycle against a
// frame-level model (expected strobe/readout cycle computed arithmetically).
module tb_spi_slave_reg_ctrl;
  localparam int RS = 8;

  logic          sclk = 1'b0, rstn = 1'b0, cs_n = 1'b1, en_qpi = 1'b0;
  logic [3:0]    sdi = 4'd0;
  logic [7:0]    dummy_cycles = 8'd0;
  logic [3:0]    sdo;
  logic          sdo_oe, wr_data_valid;
  logic [1:0]    wr_addr, rd_addr;
  logic [RS-1:0] wr_data, rd_data;

  spi_slave_reg_ctrl #(.REG_SIZE(RS)) dut (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .en_qpi(en_qpi), .dummy_cycles(dummy_cycles), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_data_valid(wr_data_valid), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 sclk = ~sclk;

  // Bench register file driven by the DUT write port.
  logic [RS-1:0] regs [4] = '{default: '0};
  assign rd_data = regs[rd_addr];
  always @(posedge sclk) if (wr_data_valid) regs[wr_addr] <= wr_data;

  // Model state and per-cycle expectations.
  logic [RS-1:0] mregs [4] = '{default: '0};
  logic [1:0]    mwa = 2'd0, mra = 2'd0;
  logic          e_wv = 0, e_oe = 0, e_sdo_chk = 0, chk_en = 0;
  logic [RS-1:0] e_wd = '0;
  logic [1:0]    e_wa = 0, e_ra = 0;
  logic [3:0]    e_sdo = 0;
  int            fcyc = -1;
  int            nvec = 0, nerr = 0;

  // Capture for literal checks.
  int            wcnt = 0, w_at = 0, ocnt = 0, first_oe = -1;
  logic [1:0]    lw_a = 0;
  logic [RS-1:0] lw_d = 0, rd_cap = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] chunk(input logic [31:0] v, input int w, input int l, input int j);
    return 4'((v >> (w - l*(j+1))) & ((32'd1 << l) - 1));
  endfunction

  // Compare process: outputs sampled 3 time units after each falling edge.
  initial begin
    forever begin
      @(negedge sclk); #3;
      if (chk_en) begin
        chk("wr_data_valid", 32'(wr_data_valid), 32'(e_wv));
        chk("wr_data", 32'(wr_data), 32'(e_wd));
        chk("wr_addr", 32'(wr_addr), 32'(e_wa));
        chk("rd_addr", 32'(rd_addr), 32'(e_ra));
        chk("sdo_oe", 32'(sdo_oe), 32'(e_oe));
        if (e_sdo_chk) chk("sdo", 32'(sdo), 32'(e_sdo));
      end
    end
  end

  always @(posedge sclk) begin
    if (wr_data_valid) begin
      wcnt++; w_at = fcyc + 1; lw_a = wr_addr; lw_d = wr_data;
    end
  end

  initial begin
    forever begin
      @(negedge sclk); #3;
      if (sdo_oe) begin
        if (first_oe < 0) first_oe = fcyc;
        rd_cap = {rd_cap[RS-2:0], sdo[0]};
        ocnt++;
      end
    end
  end

  task automatic clr_cap();
    wcnt = 0; w_at = 0; ocnt = 0; first_oe = -1; rd_cap = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk); #1;
      cs_n = 1'b1; rstn = 1'b1; fcyc = -1; sdi = 4'($urandom);
      e_wv = 0; e_wd = '0; e_oe = 0; e_sdo_chk = 0; e_wa = mwa; e_ra = mra;
    end
  endtask

  // One cs_n-low frame of len clocks; rst_at >= 0 pulses rstn at that clock.
  task automatic frame(input logic [7:0] c, input logic [RS-1:0] data, input bit q,
                       input logic [7:0] dc, input int len, input int rst_at);
    int L, ncmd, nd, D, j;
    bit is_wr, is_rd, was_rst;
    logic [RS-1:0] rv;
    logic [1:0] a;
    logic [3:0] x, r;
    L = q ? 4 : 1; ncmd = 8 / L; nd = RS / L;
    D = (dc == 8'd0) ? 1 : int'(dc);
    is_wr = (c[7:2] == 6'h1C); is_rd = (c[7:2] == 6'h1D);
    a = c[1:0]; rv = mregs[a]; was_rst = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge sclk); #1;
      cs_n = 1'b0; en_qpi = q; dummy_cycles = dc; fcyc = k;
      r = 4'($urandom); x = r;
      if (k < ncmd) x = chunk(32'(c), 8, L, k);
      else if (is_wr && k < ncmd + nd) x = chunk(32'(data), RS, L, k - ncmd);
      sdi = q ? x : {r[3:1], x[0]};
      if (k == rst_at) begin
        rstn = 1'b0; mwa = 0; mra = 0;
        e_wv = 0; e_wd = '0; e_wa = 0; e_ra = 0; e_oe = 0; e_sdo = 0; e_sdo_chk = 1;
        #1;
        chk("rst_sdo_oe", 32'(sdo_oe), 32'd0);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_valid", 32'(wr_data_valid), 32'd0);
        was_rst = 1;
        break;
      end
      e_wa = (k >= ncmd) ? a : mwa;
      e_ra = (k >= ncmd) ? a : mra;
      e_wv = is_wr && (k == ncmd + nd - 1);
      e_wd = e_wv ? data : '0;
      if (e_wv) mregs[a] = data;
      j = k - ncmd - D;
      e_oe = is_rd && (j >= 0) && (j < nd);
      e_sdo = q ? chunk(32'(rv), RS, 4, j) : {3'b000, chunk(32'(rv), RS, 1, j)[0]};
      e_sdo_chk = e_oe;
    end
    if (!was_rst && len >= ncmd) begin mwa = a; mra = a; end
    idle(1);
  endtask

  initial begin
    #3;
    chk("reset_sdo", 32'(sdo), 32'd0);
    chk("reset_sdo_oe", 32'(sdo_oe), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    chk("reset_wr_valid", 32'(wr_data_valid), 32'd0);
    chk_en = 1;
    idle(2);

    // Single write 0x71 / 0xA5.
    clr_cap();
    frame(8'h71, 8'hA5, 0, 8'd0, 16, -1);
    chk("tp1_count", 32'(wcnt), 32'd1);
    chk("tp1_edge", 32'(w_at), 32'd16);
    chk("tp1_addr", 32'(lw_a), 32'd1);
    chk("tp1_data", 32'(lw_d), 32'hA5);
    idle(2);

    // Read 0x76 of 0x3C with 4 dummy cycles.
    frame(8'h72, 8'h3C, 0, 8'd0, 16, -1);
    clr_cap();
    frame(8'h76, 8'h00, 0, 8'd4, 21, -1);
    chk("tp2_bits", 32'(rd_cap), 32'h3C);
    chk("tp2_count", 32'(ocnt), 32'd8);
    chk("tp2_first", 32'(first_oe), 32'd12);
    idle(2);

`ifdef SPI_REG_CTRL_QPI_EN
    clr_cap();
    frame(8'h73, 8'h5A, 1, 8'd0, 4, -1);
    chk("tp3_count", 32'(wcnt), 32'd1);
    chk("tp3_edge", 32'(w_at), 32'd4);
    chk("tp3_addr", 32'(lw_a), 32'd3);
    chk("tp3_data", 32'(lw_d), 32'h5A);
    idle(2);
`endif

    // Invalid opcode then 16 clocks.
    clr_cap();
    frame(8'hFF, 8'h00, 0, 8'd0, 24, -1);
    chk("tp4_writes", 32'(wcnt), 32'd0);
    chk("tp4_oe", 32'(ocnt), 32'd0);

    // Aborted write then a fresh one.
    clr_cap();
    frame(8'h70, 8'h11, 0, 8'd0, 12, -1);
    chk("tp5_abort", 32'(wcnt), 32'd0);
    idle(1);
    frame(8'h70, 8'h11, 0, 8'd0, 16, -1);
    chk("tp5_count", 32'(wcnt), 32'd1);
    chk("tp5_addr", 32'(lw_a), 32'd0);
    chk("tp5_data", 32'(lw_d), 32'h11);
    idle(2);

    // Reset pulse in the middle of read data.
    frame(8'h71, 8'hC3, 0, 8'd0, 16, -1);
    frame(8'h75, 8'h00, 0, 8'd1, 21, 12);
    idle(2);

    // Randomized frames.
    for (int n = 0; n < 80; n++) begin
      logic [7:0] c, dc;
      logic [RS-1:0] d;
      bit q;
      int sel, L, D, need, len;
      sel = int'($urandom % 3);
`ifdef SPI_REG_CTRL_QPI_EN
      q = bit'($urandom % 2);
`else
      q = 1'b0;
`endif
      dc = 8'($urandom % 6);
      d = RS'($urandom);
      L = q ? 4 : 1;
      D = (dc == 8'd0) ? 1 : int'(dc);
      if (sel == 0) begin
        c = {6'h1C, 2'($urandom)}; need = 8/L + RS/L;
      end else if (sel == 1) begin
        c = {6'h1D, 2'($urandom)}; need = 8/L + D + RS/L + 1;
      end else begin
        c = 8'($urandom);
        while (c[7:3] == 5'b01110) c = 8'($urandom);
        need = 8/L + 2;
      end
      len = need + int'($urandom % 3);
      if ($urandom % 6 == 0) len = 1 + int'($urandom % (need - 1));
      frame(c, d, q, dc, len, -1);
      idle(1 + int'($urandom % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
